// File: rtl/training_pkg.sv
// training_pkg: shared FSM state encoding and optimizer-select codes for the training controller.
package training_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, START, WAIT, DONE} state_e;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ADAM = 2'b01;
  localparam logic [1:0] SEL_MANH = 2'b10;
endpackage

// File: rtl/training_ctrl_fsm_popcount.sv
// flag_popcount: combinational count of set comparator flags.
module flag_popcount #(
  parameter int NUM_FLAGS = 6
) (
  input  logic [NUM_FLAGS-1:0]         flags_i,
  output logic [$clog2(NUM_FLAGS+1)-1:0] count_o
);
  localparam int CW = $clog2(NUM_FLAGS + 1);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_FLAGS; i++) count_o = count_o + CW'(flags_i[i]);
  end
endmodule

// File: rtl/training_ctrl_fsm.sv
// training_ctrl_fsm: epoch sequencer choosing Adam/Manhattan per evaluation, ending on convergence streak or epoch limit.
module training_ctrl_fsm
  import training_pkg::*;
#(
  parameter int NUM_FLAGS  = 6,
  parameter int EPOCH_W    = 16,
  parameter int PATIENCE_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           training_mode,
  input  logic                           flags_valid,
  input  logic [NUM_FLAGS-1:0]           flag_vectors_comparator,
  input  logic [$clog2(NUM_FLAGS+1)-1:0] manh_min,
  input  logic [EPOCH_W-1:0]             max_epochs,
  input  logic [PATIENCE_W-1:0]          patience,
  input  logic                           opt_done,
  output logic                           opt_start,
  output logic                           adam_signal,
  output logic                           manhatten_signal,
  output logic                           training_done,
  output logic                           training_timeout,
  output logic                           busy,
  output logic [EPOCH_W-1:0]             epoch_count
);
  localparam int CW = $clog2(NUM_FLAGS + 1);
  state_e                state_q, state_d;
  logic [EPOCH_W-1:0]    epoch_q, epoch_d, epoch_inc;
  logic [PATIENCE_W-1:0] streak_q, streak_d;
  logic [PATIENCE_W:0]   streak_nxt, need;
  logic [1:0]            sel_q, sel_d, sel_new;
  logic                  start_q, start_d, done_q, done_d, timeout_q, timeout_d, busy_q, busy_d;
  logic [CW-1:0]         pc;
  logic                  all_set, limit_hit;
  flag_popcount #(.NUM_FLAGS(NUM_FLAGS)) u_popcount (
    .flags_i (flag_vectors_comparator),
    .count_o (pc)
  );
  assign all_set    = pc == CW'(NUM_FLAGS);
  assign sel_new    = (pc >= manh_min) ? SEL_MANH : SEL_ADAM;
  assign streak_nxt = {1'b0, streak_q} + (PATIENCE_W+1)'(1);
  assign need       = (patience == '0) ? (PATIENCE_W+1)'(1) : {1'b0, patience};
  assign epoch_inc  = (&epoch_q) ? epoch_q : epoch_q + EPOCH_W'(1);
  // Below the limit epoch_q never wraps, so a plain compare against max_epochs is safe.
  assign limit_hit  = (max_epochs != '0) && (epoch_q + EPOCH_W'(1) == max_epochs);
  always_comb begin
    state_d   = state_q;
    epoch_d   = epoch_q;
    streak_d  = streak_q;
    sel_d     = sel_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    if (!training_mode) begin
      state_d   = IDLE;
      epoch_d   = '0;
      streak_d  = '0;
      sel_d     = SEL_NONE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = EVAL;
          epoch_d  = '0;
          streak_d = '0;
        end
        EVAL: if (flags_valid) begin
          if (all_set) begin
            streak_d = streak_nxt[PATIENCE_W-1:0];
            state_d  = (streak_nxt >= need) ? DONE : EVAL;
            done_d   = streak_nxt >= need;
          end else begin
            streak_d = '0;
            sel_d    = sel_new;
            state_d  = START;
          end
        end
        START: state_d = WAIT;
        WAIT: if (opt_done) begin
          epoch_d   = epoch_inc;
          sel_d     = SEL_NONE;
          state_d   = limit_hit ? DONE : EVAL;
          done_d    = limit_hit;
          timeout_d = limit_hit;
        end
        default: ;
      endcase
    end
    start_d = state_d == START;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      epoch_q   <= '0;
      streak_q  <= '0;
      sel_q     <= SEL_NONE;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      epoch_q   <= epoch_d;
      streak_q  <= streak_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end
  assign opt_start        = start_q;
  assign adam_signal      = sel_q[0];
  assign manhatten_signal = sel_q[1];
  assign training_done    = done_q;
  assign training_timeout = timeout_q;
  assign busy             = busy_q;
  assign epoch_count      = epoch_q;
endmodule

// File: tb/tb_training_ctrl_fsm.sv
// tb_training_ctrl_fsm: directed scenario checks of the training controller with hand-computed expectations.
module tb_training_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        training_mode = 1'b0;
  logic        flags_valid = 1'b0;
  logic [5:0]  flags = '0;
  logic [2:0]  manh_min = 3'd4;
  logic [15:0] max_epochs = '0;
  logic [3:0]  patience = 4'd1;
  logic        opt_done = 1'b0;
  logic        opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy;
  logic [15:0] epoch_count;
  int          vectors = 0;
  int          miscompares = 0;
  int          start_cnt = 0;
  training_ctrl_fsm #(.NUM_FLAGS(6), .EPOCH_W(16), .PATIENCE_W(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .training_mode           (training_mode),
    .flags_valid             (flags_valid),
    .flag_vectors_comparator (flags),
    .manh_min                (manh_min),
    .max_epochs              (max_epochs),
    .patience                (patience),
    .opt_done                (opt_done),
    .opt_start               (opt_start),
    .adam_signal             (adam_signal),
    .manhatten_signal        (manhatten_signal),
    .training_done           (training_done),
    .training_timeout        (training_timeout),
    .busy                    (busy),
    .epoch_count             (epoch_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (opt_start) start_cnt <= start_cnt + 1;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic eval(input logic [5:0] f);
    flags = f; flags_valid = 1'b1; tick(); flags_valid = 1'b0;
  endtask
  task automatic finish_opt;
    opt_done = 1'b1; tick(); opt_done = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; training_mode = 1'b1; tick(2);
    vectors++; if ({opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy} !== 6'b0) begin miscompares++; $display("FAIL reset_outs: got %b expected 000000", {opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy}); end
    vectors++; if (epoch_count !== 16'd0) begin miscompares++; $display("FAIL reset_epoch: got %0d expected 0", epoch_count); end
    training_mode = 1'b0; rst = 1'b0; tick();
  endtask
  task automatic test_converged_first;
    int s0;
    patience = 4'd1; max_epochs = '0; manh_min = 3'd4; s0 = start_cnt;
    training_mode = 1'b1; tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL conv_busy_eval: got %b expected 1", busy); end
    eval(6'b111111);
    vectors++; if ({training_done, training_timeout, busy} !== 3'b100) begin miscompares++; $display("FAIL conv_done: got %b expected 100", {training_done, training_timeout, busy}); end
    tick(2);
    vectors++; if (training_done !== 1'b1) begin miscompares++; $display("FAIL conv_done_held: got %b expected 1", training_done); end
    vectors++; if (epoch_count !== 16'd0) begin miscompares++; $display("FAIL conv_epoch: got %0d expected 0", epoch_count); end
    vectors++; if (start_cnt !== s0) begin miscompares++; $display("FAIL conv_no_start: got %0d pulses expected 0", start_cnt - s0); end
    training_mode = 1'b0; tick();
    vectors++; if (training_done !== 1'b0) begin miscompares++; $display("FAIL conv_done_clear: got %b expected 0", training_done); end
  endtask
  task automatic test_optimizer_select;
    manh_min = 3'd4; training_mode = 1'b1; tick();
    eval(6'b001111);
    vectors++; if ({opt_start, manhatten_signal, adam_signal} !== 3'b110) begin miscompares++; $display("FAIL sel_manh_start: got %b expected 110", {opt_start, manhatten_signal, adam_signal}); end
    tick(2);
    vectors++; if ({opt_start, manhatten_signal, adam_signal} !== 3'b010) begin miscompares++; $display("FAIL sel_manh_wait: got %b expected 010", {opt_start, manhatten_signal, adam_signal}); end
    finish_opt();
    vectors++; if ({manhatten_signal, adam_signal, epoch_count} !== {2'b00, 16'd1}) begin miscompares++; $display("FAIL sel_manh_clear: got %b/%0d expected 00/1", {manhatten_signal, adam_signal}, epoch_count); end
    eval(6'b000011);
    vectors++; if ({opt_start, manhatten_signal, adam_signal} !== 3'b101) begin miscompares++; $display("FAIL sel_adam_start: got %b expected 101", {opt_start, manhatten_signal, adam_signal}); end
    tick(); finish_opt();
    manh_min = 3'd0; eval(6'b000000);
    vectors++; if ({manhatten_signal, adam_signal} !== 2'b10) begin miscompares++; $display("FAIL sel_min0: got %b expected 10", {manhatten_signal, adam_signal}); end
    tick(); finish_opt();
    manh_min = 3'd6; eval(6'b011111);
    vectors++; if ({manhatten_signal, adam_signal} !== 2'b01) begin miscompares++; $display("FAIL sel_min6: got %b expected 01", {manhatten_signal, adam_signal}); end
    tick(); finish_opt();
    vectors++; if (epoch_count !== 16'd4) begin miscompares++; $display("FAIL sel_epoch: got %0d expected 4", epoch_count); end
    manh_min = 3'd4; training_mode = 1'b0; tick();
  endtask
  task automatic test_patience;
    patience = 4'd3; training_mode = 1'b1; tick();
    eval(6'b111111);
    eval(6'b000001); tick(); finish_opt();
    eval(6'b111111);
    eval(6'b111111);
    vectors++; if (training_done !== 1'b0) begin miscompares++; $display("FAIL pat_early: got %b expected 0", training_done); end
    eval(6'b111111);
    vectors++; if ({training_done, training_timeout, epoch_count} !== {2'b10, 16'd1}) begin miscompares++; $display("FAIL pat_done: got %b/%0d expected 10/1", {training_done, training_timeout}, epoch_count); end
    patience = 4'd1; training_mode = 1'b0; tick();
  endtask
  task automatic test_timeout;
    max_epochs = 16'd5; training_mode = 1'b1; tick();
    for (int e = 1; e <= 5; e++) begin
      eval(6'b010101); tick(3); finish_opt();
      if (e == 4) begin
        vectors++; if ({training_done, epoch_count} !== {1'b0, 16'd4}) begin miscompares++; $display("FAIL to_ep4: got %b/%0d expected 0/4", training_done, epoch_count); end
      end
    end
    vectors++; if ({training_done, training_timeout, busy} !== 3'b110) begin miscompares++; $display("FAIL to_done: got %b expected 110", {training_done, training_timeout, busy}); end
    vectors++; if (epoch_count !== 16'd5) begin miscompares++; $display("FAIL to_epoch: got %0d expected 5", epoch_count); end
    max_epochs = '0; training_mode = 1'b0; tick();
    vectors++; if ({training_done, training_timeout} !== 2'b00) begin miscompares++; $display("FAIL to_clear: got %b expected 00", {training_done, training_timeout}); end
  endtask
  task automatic test_mode_drop;
    training_mode = 1'b1; tick();
    eval(6'b000001); tick(); finish_opt();
    eval(6'b000001); tick();
    training_mode = 1'b0; opt_done = 1'b1; tick(); opt_done = 1'b0;
    vectors++; if ({opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy} !== 6'b0) begin miscompares++; $display("FAIL drop_outs: got %b expected 000000", {opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy}); end
    vectors++; if (epoch_count !== 16'd0) begin miscompares++; $display("FAIL drop_epoch: got %0d expected 0", epoch_count); end
    training_mode = 1'b1; tick();
    eval(6'b000111);
    vectors++; if ({opt_start, adam_signal, busy, epoch_count} !== {3'b111, 16'd0}) begin miscompares++; $display("FAIL drop_restart: got %b/%0d expected 111/0", {opt_start, adam_signal, busy}, epoch_count); end
    training_mode = 1'b0; tick();
  endtask
  task automatic test_rst_mid_wait;
    training_mode = 1'b1; tick();
    eval(6'b110000); tick();
    eval(6'b111111);
    vectors++; if ({opt_start, adam_signal, busy, training_done} !== 4'b0110) begin miscompares++; $display("FAIL spur_flags: got %b expected 0110", {opt_start, adam_signal, busy, training_done}); end
    rst = 1'b1; tick();
    vectors++; if ({opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy, epoch_count} !== 22'd0) begin miscompares++; $display("FAIL rst_wait: got %b/%0d expected 0", {opt_start, adam_signal, manhatten_signal, training_done, training_timeout, busy}, epoch_count); end
    rst = 1'b0; tick();
    finish_opt();
    vectors++; if ({opt_start, busy, epoch_count} !== {2'b01, 16'd0}) begin miscompares++; $display("FAIL spur_done: got %b/%0d expected 01/0", {opt_start, busy}, epoch_count); end
    eval(6'b111111);
    vectors++; if ({training_done, epoch_count} !== {1'b1, 16'd0}) begin miscompares++; $display("FAIL rst_resume: got %b/%0d expected 1/0", training_done, epoch_count); end
    training_mode = 1'b0; tick();
  endtask
  initial begin
    test_reset();
    test_converged_first();
    test_optimizer_select();
    test_patience();
    test_timeout();
    test_mode_drop();
    test_rst_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
